rv32i_issue_scoreboard: RTL
===========================

Name: rv32i_issue_scoreboard

Overview:
- In-order issue controller between the RV32I fetch/decode front end and the execute units.
- Decodes each accepted instruction with the shared rv32 field extraction, then holds it in a one-entry issue register.
- Tracks in-flight destination registers in a per-register pending-count scoreboard and releases an instruction only once it has no RAW hazard and no WAW-count overflow.
- Writebacks retire pending counts; flush clears everything.

Parameters:
- PENDING_WIDTH, 2: bits per register pending counter; max outstanding writes per register = 2^PENDING_WIDTH-1.
- NUM_WB, 2: number of independent writeback retire ports.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- inst_valid  input  1  front-end instruction valid
- inst_ready  output  1  block can accept an instruction
- inst_data  input  32  raw instruction word
- issue_valid  output  1  held instruction is hazard-free and offered
- issue_ready  input  1  execute accepts
- issue_fields  output  $bits(rv32_fields_t)  decoded fields of held instruction, imm included
- issue_rd_use  output  1  instruction writes rd (rd != x0)
- issue_illegal  output  1  opcode not in rv32i_opcode_t
- wb_valid  input  NUM_WB  per-port writeback strobe
- wb_rd  input  NUM_WB*5  per-port destination register
- flush  input  1  discard held instruction and clear scoreboard
- busy  output  1  any pending count nonzero or entry held

Behaviour:
- Reset (async, rst=1): entry empty, all counters 0, inst_ready=0 while rst is high, issue_valid=0, busy=0, issue_fields='0, issue_rd_use=0, issue_illegal=0.
- Decode at accept: fields from rv32_get_fields(inst_data) registered with use flags.
  - rs1_use: OP, STORE, BRANCH, IMM, LOAD, JALR, SYSTEM.
  - rs2_use: OP, STORE, BRANCH.
  - rd_use: OP, IMM, LOAD, LUI, AUIPC, JAL, JALR, SYSTEM, and rd != 0.
  - Illegal opcode: all use flags 0, issue_illegal=1; the instruction still issues, so a trap can be taken downstream.
- States: EMPTY, HELD.
  - EMPTY -> HELD on inst_valid&&inst_ready.
  - HELD -> EMPTY on issue handshake without a new accept.
  - HELD -> HELD on issue handshake with a simultaneous accept (back-to-back).
  - Any state -> EMPTY on flush.
- inst_ready = !flush && (EMPTY || (issue_valid && issue_ready)).
- Latency: an instruction accepted in cycle N can issue in cycle N+1 at the earliest. Sustained throughput is 1/cycle with no hazards.
- Effective count eff[r] = count[r] minus the number of wb ports retiring r this cycle, floored at 0. This is a same-cycle writeback bypass.
- hazard = (rs1_use && rs1!=0 && eff[rs1]!=0) || (rs2_use && rs2!=0 && eff[rs2]!=0) || (rd_use && eff[rd]==max).
- issue_valid = HELD && !hazard && !flush.
- Counter update per register per cycle: count' = count + (issue handshake && rd_use && rd==r) - retires(r).
  - Saturates at 0.
  - A retire on a register with count 0 is ignored; simulation assertion fires.
  - Simultaneous +1 and -1 on the same register is net 0.
- x0 is never counted; a writeback to x0 is ignored.
- Dependence on the issuing instruction: the next held instruction sees the updated counter on the following cycle. No false-clear is possible because the increment is registered before that instruction's first eligible cycle.
- flush: counters cleared and entry dropped at the next edge. An accept or issue in the flush cycle is suppressed (inst_ready=0, issue_valid=0). Writebacks in the flush cycle are discarded.
- issue_valid must not drop while issue_ready is low unless flush is asserted.
- issue_fields must stay stable while issue_valid && !issue_ready.
- busy = HELD || |counts.

Decomposition:
- Shared package rv32i gains:
  - rv32i_reg_use_t, a packed struct {rs1_use, rs2_use, rd_use, illegal}.
  - rv32i_get_reg_use(rv32_fields_t), a function next to rv32_get_fields.
- Sub-module rv32i_scoreboard_counters: count array, retire summation, eff[] generation, flush clear.
- The top level holds the entry FSM, handshake and hazard logic.

Test Plan:
- Independent stream: addi x1,x0,5 (0x00500093), then addi x2,x0,7 (0x00700113), issue_ready=1 -> issues on cycles N+1 and N+2; count[1]=1 and count[2]=1.
- RAW stall: issue 0x00500093, no wb, then add x3,x1,x2 (0x002081B3) -> issue_valid=0 held. wb_valid[0]=1, wb_rd=1 and wb for x2 -> add issues in the same cycle (bypass).
- WAW saturation, PENDING_WIDTH=2: three addi x1 issued without wb, fourth held (count[1]=3). One wb to x1 -> fourth issues that cycle; count stays 3.
- Store/branch no rd: sw x5,0(x1) (0x0050A023) issues with issue_rd_use=0. Illegal word 0x0000007F issues with issue_illegal=1 and no counter change.
- Flush: held stalled add, counts nonzero, flush=1 with inst_valid=1 -> next cycle EMPTY, all counts 0, busy=0, nothing accepted.
- Reset mid-stream: rst asserted during a stall -> outputs reset immediately (async). After release, wb_rd=1 with count 0 is ignored and the assertion fires.

Source files
------------

// File: rtl/rv32i_issue_scoreboard_pkg.sv
// Package for the RV32I issue scoreboard.
// Holds the RV32I opcode enumeration, the decoded instruction field struct,
// the per-instruction register-use struct, and the decode helper functions
// shared by the front end and the issue logic.
package rv32i_issue_scoreboard_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_IMM      = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } rv32i_opcode_t;

  typedef struct packed {
    logic [6:0]  funct7;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [31:0] imm;
  } rv32_fields_t;

  typedef struct packed {
    logic rs1_use;
    logic rs2_use;
    logic rd_use;
    logic illegal;
  } rv32i_reg_use_t;

  // Raw field extraction plus the sign-extended immediate for the format
  // implied by the opcode. Formats without an immediate yield zero.
  function automatic rv32_fields_t rv32_get_fields(input logic [31:0] inst);
    rv32_fields_t f;
    f.funct7 = inst[31:25];
    f.rs2    = inst[24:20];
    f.rs1    = inst[19:15];
    f.funct3 = inst[14:12];
    f.rd     = inst[11:7];
    f.opcode = inst[6:0];
    case (inst[6:0])
      OPC_LOAD, OPC_IMM, OPC_JALR, OPC_SYSTEM:
        f.imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        f.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        f.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        f.imm = {inst[31:12], 12'b0};
      OPC_JAL:
        f.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        f.imm = 32'b0;
    endcase
    return f;
  endfunction

  // Which architectural registers an instruction reads and writes.
  // Unknown opcodes report no register use so they never stall or count.
  function automatic rv32i_reg_use_t rv32i_get_reg_use(input rv32_fields_t f);
    rv32i_reg_use_t u;
    u = '0;
    case (f.opcode)
      OPC_OP:                 begin u.rs1_use = 1'b1; u.rs2_use = 1'b1; u.rd_use = 1'b1; end
      OPC_STORE, OPC_BRANCH:  begin u.rs1_use = 1'b1; u.rs2_use = 1'b1; end
      OPC_IMM, OPC_LOAD,
      OPC_JALR, OPC_SYSTEM:   begin u.rs1_use = 1'b1; u.rd_use = 1'b1; end
      OPC_LUI, OPC_AUIPC,
      OPC_JAL:                u.rd_use = 1'b1;
      OPC_MISC_MEM:           u = '0;
      default:                u.illegal = 1'b1;
    endcase
    if (f.rd == 5'd0) u.rd_use = 1'b0;
    return u;
  endfunction

endpackage

// File: rtl/rv32i_issue_scoreboard_counters.sv
// Per-register pending-write counters.
// Ports:
//   i_clk, i_rst         clock, async active-high reset
//   i_flush              clear all counters at the next edge, drop writebacks
//   i_inc_valid/i_inc_rd increment request from the issue handshake
//   i_wb_valid/i_wb_rd   NUM_WB writeback retire ports (5 bits each)
//   o_eff                per-register count after this cycle's retires
//   o_any_pending        any counter nonzero
module rv32i_issue_scoreboard_counters #(
  parameter int PENDING_WIDTH = 2,
  parameter int NUM_WB        = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_flush,
  input  logic                          i_inc_valid,
  input  logic [4:0]                    i_inc_rd,
  input  logic [NUM_WB-1:0]             i_wb_valid,
  input  logic [NUM_WB*5-1:0]           i_wb_rd,
  output logic [31:0][PENDING_WIDTH-1:0] o_eff,
  output logic                          o_any_pending
);

  localparam int RW = $clog2(NUM_WB + 1);
  localparam int SW = ((PENDING_WIDTH > RW) ? PENDING_WIDTH : RW) + 1;
  localparam logic [SW-1:0] MAXC = SW'((1 << PENDING_WIDTH) - 1);

  logic [31:0][PENDING_WIDTH-1:0] r_count;
  logic [31:0][PENDING_WIDTH-1:0] w_next;
  logic [31:0]                    w_over_retire;
  logic [SW-1:0]                  w_ret;
  logic [SW-1:0]                  w_cnt;
  logic [SW-1:0]                  w_eff;
  logic [SW-1:0]                  w_nxt;

  always_comb begin
    w_next        = '0;
    o_eff         = '0;
    w_over_retire = '0;
    w_ret         = '0;
    w_cnt         = '0;
    w_eff         = '0;
    w_nxt         = '0;
    // x0 (index 0) is left at zero: never counted, writebacks to it ignored.
    for (int r = 1; r < 32; r++) begin
      w_ret = '0;
      for (int p = 0; p < NUM_WB; p++) begin
        if (i_wb_valid[p] && (i_wb_rd[p*5 +: 5] == 5'(r))) w_ret = w_ret + SW'(1);
      end
      w_cnt = SW'(r_count[r]);
      // Retires beyond the outstanding count are dropped (floor at zero).
      w_over_retire[r] = (w_ret > w_cnt);
      w_eff = (w_ret > w_cnt) ? '0 : (w_cnt - w_ret);
      o_eff[r] = w_eff[PENDING_WIDTH-1:0];
      w_nxt = w_eff;
      if (i_inc_valid && (i_inc_rd == 5'(r))) w_nxt = w_eff + SW'(1);
      if (w_nxt > MAXC) w_nxt = MAXC;
      w_next[r] = w_nxt[PENDING_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_count <= '0;
    else if (i_flush) r_count <= '0;
    else              r_count <= w_next;
  end

  assign o_any_pending = |r_count;

  always @(posedge i_clk) begin
    if (!i_rst && !i_flush)
      assert (w_over_retire == '0)
        else $warning("writeback retired a register with no pending write; ignored");
  end

endmodule

// File: rtl/rv32i_issue_scoreboard.sv
// In-order issue controller with a one-entry issue register and a
// per-register pending-write scoreboard.
// Ports:
//   i_clk, i_rst              clock, async active-high reset
//   i_inst_valid/o_inst_ready front-end handshake, i_inst_data raw word
//   o_issue_valid/i_issue_ready execute handshake
//   o_issue_fields            decoded fields of the held instruction
//   o_issue_rd_use            held instruction writes a nonzero rd
//   o_issue_illegal           held instruction has an unknown opcode
//   i_wb_valid/i_wb_rd        writeback retire ports
//   i_flush                   drop held entry and clear scoreboard
//   o_busy                    entry held or any write pending
module rv32i_issue_scoreboard
  import rv32i_issue_scoreboard_pkg::*;
#(
  parameter int PENDING_WIDTH = 2,
  parameter int NUM_WB        = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_inst_valid,
  output logic                o_inst_ready,
  input  logic [31:0]         i_inst_data,
  output logic                o_issue_valid,
  input  logic                i_issue_ready,
  output rv32_fields_t        o_issue_fields,
  output logic                o_issue_rd_use,
  output logic                o_issue_illegal,
  input  logic [NUM_WB-1:0]   i_wb_valid,
  input  logic [NUM_WB*5-1:0] i_wb_rd,
  input  logic                i_flush,
  output logic                o_busy
);

  // state    | meaning
  // ST_EMPTY | no instruction held, ready to accept
  // ST_HELD  | instruction held, offered once hazard-free
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;

  localparam logic [PENDING_WIDTH-1:0] MAXC = '1;

  logic [0:0]     r_state;
  rv32_fields_t   r_fields;
  rv32i_reg_use_t r_use;

  logic [31:0][PENDING_WIDTH-1:0] w_eff;
  logic                           w_any_pending;
  logic                           w_hazard;
  logic                           w_issue;
  logic                           w_accept;
  rv32_fields_t                   w_dec_fields;

  assign w_dec_fields = rv32_get_fields(i_inst_data);

  // Hazards use the post-retire count, so a writeback in this cycle
  // releases a dependent instruction in the same cycle.
  always_comb begin
    w_hazard = 1'b0;
    if (r_use.rs1_use && (r_fields.rs1 != 5'd0) && (w_eff[r_fields.rs1] != '0)) w_hazard = 1'b1;
    if (r_use.rs2_use && (r_fields.rs2 != 5'd0) && (w_eff[r_fields.rs2] != '0)) w_hazard = 1'b1;
    if (r_use.rd_use && (w_eff[r_fields.rd] == MAXC)) w_hazard = 1'b1;
  end

  assign o_issue_valid = (r_state == ST_HELD) && !w_hazard && !i_flush;
  assign w_issue       = o_issue_valid && i_issue_ready;
  assign o_inst_ready  = !i_rst && !i_flush && ((r_state == ST_EMPTY) || w_issue);
  assign w_accept      = i_inst_valid && o_inst_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_EMPTY;
      r_fields <= '0;
      r_use    <= '0;
    end else if (i_flush) begin
      r_state <= ST_EMPTY;
    end else if (w_accept) begin
      r_state  <= ST_HELD;
      r_fields <= w_dec_fields;
      r_use    <= rv32i_get_reg_use(w_dec_fields);
    end else if (w_issue) begin
      r_state <= ST_EMPTY;
    end
  end

  rv32i_issue_scoreboard_counters #(
    .PENDING_WIDTH(PENDING_WIDTH),
    .NUM_WB       (NUM_WB)
  ) u_cnt (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (i_flush),
    .i_inc_valid  (w_issue && r_use.rd_use),
    .i_inc_rd     (r_fields.rd),
    .i_wb_valid   (i_wb_valid),
    .i_wb_rd      (i_wb_rd),
    .o_eff        (w_eff),
    .o_any_pending(w_any_pending)
  );

  assign o_issue_fields  = r_fields;
  assign o_issue_rd_use  = r_use.rd_use;
  assign o_issue_illegal = r_use.illegal;
  assign o_busy          = (r_state == ST_HELD) || w_any_pending;

endmodule
